ace_rd_mem_responder: RTL

- Subordinate end of the core's ACE read-address/read-data channels (AR/R/RACK).
- Sits on the interconnect/memory side and services the ifu or lsu line-fill reads from an internal line-wide memory array.
- Configurable fixed latency; one outstanding transaction, closed by RACK.
- Used as the simulation memory model and as a single-port on-chip boot memory.

---
 rtl/offnariscv_pkg.sv | 40 ++++
 rtl/ace_rd_mem_responder_if.sv | 40 ++++
 rtl/ace_rd_mem_array.sv | 28 ++
 rtl/ace_rd_mem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/offnariscv_pkg.sv
// Shared ACE widths, burst/response encodings and the read-responder FSM states.
// Consumed by ace_rd_mem_responder and its interface.
package offnariscv_pkg;

  localparam int ACE_XID_WIDTH      = 4;
  localparam int ACE_AXADDR_WIDTH   = 32;
  localparam int ACE_AXLEN_WIDTH    = 8;
  localparam int ACE_AXSIZE_WIDTH   = 3;
  localparam int ACE_AXBURST_WIDTH  = 2;
  localparam int ACE_XDATA_WIDTH    = 256;
  localparam int ACE_RRESP_WIDTH    = 4;
  localparam int ACE_LINE_SIZE_LOG2 = 5;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } ace_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } ace_resp_e;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_LAT,
    RS_DATA,
    RS_ACK
  } ace_rd_resp_state_e;

  function automatic logic wrap_len_ok(
    logic [ACE_AXLEN_WIDTH-1:0] len
  );
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

endpackage

// File: rtl/ace_rd_mem_responder_if.sv
// ACE AR/R/RACK bundle; master = core side, slave = memory responder.
interface ace_rd_mem_responder_if
  import offnariscv_pkg::*;
#(
  parameter int AW = ACE_AXADDR_WIDTH,
  parameter int DW = ACE_XDATA_WIDTH
) ();

  logic [ACE_XID_WIDTH-1:0]     ace_arid;
  logic [AW-1:0]                ace_araddr;
  logic [ACE_AXLEN_WIDTH-1:0]   ace_arlen;
  logic [ACE_AXSIZE_WIDTH-1:0]  ace_arsize;
  logic [ACE_AXBURST_WIDTH-1:0] ace_arburst;
  logic                         ace_arvalid;
  logic                         ace_arready;
  logic [ACE_XID_WIDTH-1:0]     ace_rid;
  logic [DW-1:0]                ace_rdata;
  logic [ACE_RRESP_WIDTH-1:0]   ace_rresp;
  logic                         ace_rlast;
  logic                         ace_rvalid;
  logic                         ace_rready;
  logic                         ace_rack;

  modport master (
    output ace_arid, ace_araddr, ace_arlen,
    output ace_arsize, ace_arburst, ace_arvalid,
    output ace_rready, ace_rack,
    input  ace_arready, ace_rid, ace_rdata,
    input  ace_rresp, ace_rlast, ace_rvalid
  );

  modport slave (
    input  ace_arid, ace_araddr, ace_arlen,
    input  ace_arsize, ace_arburst, ace_arvalid,
    input  ace_rready, ace_rack,
    output ace_arready, ace_rid, ace_rdata,
    output ace_rresp, ace_rlast, ace_rvalid
  );

endinterface

// File: rtl/ace_rd_mem_array.sv
// Line-wide synchronous RAM, one read and one write port.
// A write in a cycle suppresses that cycle's read.
module ace_rd_mem_array #(
  parameter int LINES = 1024,
  parameter int DW    = 256
) (
  input  logic                     clk,
  input  logic [$clog2(LINES)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata,
  input  logic                     i_we,
  input  logic [$clog2(LINES)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata
);

  logic [DW-1:0] r_mem [LINES];
  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end else begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/ace_rd_mem_responder.sv
// ACE read subordinate backed by a line RAM, fixed latency, one outstanding.
// ACE_RD_MEM_RESPONDER_BACKDOOR_EN adds the bd_* preload write port.
module ace_rd_mem_responder #(
  parameter int ACE_XDATA_WIDTH  = 256,
  parameter int ACE_AXADDR_WIDTH = 32,
  parameter int MEM_LINES        = 1024,
  parameter int RD_LATENCY       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ace_rd_mem_responder_if.slave        ace,
`ifdef ACE_RD_MEM_RESPONDER_BACKDOOR_EN
  input  logic                         bd_we,
  input  logic [$clog2(MEM_LINES)-1:0] bd_line,
  input  logic [ACE_XDATA_WIDTH-1:0]   bd_wdata,
`endif
  output logic                         proto_err
);

  import offnariscv_pkg::*;

  localparam int LW   = $clog2(MEM_LINES);
  localparam int IW   = ACE_AXADDR_WIDTH - ACE_LINE_SIZE_LOG2;
  localparam int LENW = ACE_AXLEN_WIDTH;
  localparam logic [3:0] LAT_INIT =
    4'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);

  ace_rd_resp_state_e         r_state;
  ace_burst_e                 r_burst;
  logic [3:0]                 r_lat;
  logic [ACE_XID_WIDTH-1:0]   r_id;
  logic [IW-1:0]              r_base;
  logic [LENW-1:0]            r_len;
  logic [LENW-1:0]            r_beat;
  logic                       r_serr;
  logic                       r_err;
  logic                       r_arready;
  logic                       r_rvalid;
  logic                       r_rack_q;
  logic                       r_proto_err;

  logic                       w_ar_hs;
  logic                       w_r_hs;
  logic [IW-1:0]              w_pf_base;
  logic [IW-1:0]              w_pf_idx;
  logic [IW-1:0]              w_inc;
  logic [IW-1:0]              w_mask;
  logic [LENW-1:0]            w_pf_beat;
  logic                       w_pf_serr;
  logic                       w_pf_err;
  ace_burst_e                 w_burst;
  logic                       w_bad_wrap;
  ace_resp_e                  w_resp;
  logic [ACE_XDATA_WIDTH-1:0] w_q;
  logic                       w_we;
  logic [LW-1:0]              w_wline;
  logic [ACE_XDATA_WIDTH-1:0] w_wdata;
  logic                       w_unused;

  assign w_ar_hs  = ace.ace_arvalid & r_arready;
  assign w_r_hs   = r_rvalid & ace.ace_rready;
  assign w_unused = ^ace.ace_araddr[ACE_LINE_SIZE_LOG2-1:0];

  always_comb begin
    w_burst    = BURST_INCR;
    w_bad_wrap = 1'b0;
    unique case (ace.ace_arburst)
      2'd0: w_burst = BURST_FIXED;
      2'd2: begin
        w_bad_wrap = !wrap_len_ok(ace.ace_arlen);
        w_burst    = w_bad_wrap ? BURST_INCR : BURST_WRAP;
      end
      default: w_burst = BURST_INCR;
    endcase
  end

  // Prefetch the line that will be on the bus next cycle
  always_comb begin
    w_pf_base = r_base;
    w_pf_beat = r_beat + LENW'(w_r_hs);
    w_pf_serr = r_serr;
    if (r_state == RS_IDLE) begin
      w_pf_base = ace.ace_araddr[ACE_AXADDR_WIDTH-1:ACE_LINE_SIZE_LOG2];
      w_pf_beat = '0;
      w_pf_serr = ace.ace_arsize
                  != ACE_AXSIZE_WIDTH'(ACE_LINE_SIZE_LOG2);
    end
    w_inc  = w_pf_base + IW'(w_pf_beat);
    w_mask = IW'(r_len);
    unique case (r_burst)
      BURST_FIXED: w_pf_idx = w_pf_base;
      BURST_WRAP:  w_pf_idx = (w_pf_base & ~w_mask) | (w_inc & w_mask);
      default:     w_pf_idx = w_inc;
    endcase
    w_pf_err = w_pf_serr | (|(w_pf_idx >> LW));
  end

`ifdef ACE_RD_MEM_RESPONDER_BACKDOOR_EN
  assign w_we    = bd_we;
  assign w_wline = bd_line;
  assign w_wdata = bd_wdata;
`else
  assign w_we    = 1'b0;
  assign w_wline = '0;
  assign w_wdata = '0;
`endif

  ace_rd_mem_array #(
    .LINES (MEM_LINES),
    .DW    (ACE_XDATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_raddr (w_pf_idx[LW-1:0]),
    .o_rdata (w_q),
    .i_we    (w_we),
    .i_waddr (w_wline),
    .i_wdata (w_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RS_IDLE;
      r_burst     <= BURST_INCR;
      r_lat       <= '0;
      r_id        <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_serr      <= 1'b0;
      r_err       <= 1'b0;
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rack_q    <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_err    <= w_pf_err;
      r_rack_q <= ace.ace_rack;
      if (ace.ace_rack && (r_state != RS_ACK || r_rack_q)) begin
        r_proto_err <= 1'b1;
      end
      unique case (r_state)
        RS_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_id      <= ace.ace_arid;
            r_base    <= w_pf_base;
            r_len     <= ace.ace_arlen;
            r_beat    <= '0;
            r_serr    <= w_pf_serr;
            r_burst   <= w_burst;
            r_lat     <= LAT_INIT;
            if (w_bad_wrap) r_proto_err <= 1'b1;
            if (RD_LATENCY == 1) begin
              r_state  <= RS_DATA;
              r_rvalid <= 1'b1;
            end else begin
              r_state <= RS_LAT;
            end
          end
        end
        RS_LAT: begin
          if (r_lat == '0) begin
            r_state  <= RS_DATA;
            r_rvalid <= 1'b1;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        RS_DATA: begin
          if (w_r_hs) begin
            if (r_beat == r_len) begin
              r_state  <= RS_ACK;
              r_rvalid <= 1'b0;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        RS_ACK: begin
          if (ace.ace_rack) begin
            r_state   <= RS_IDLE;
            r_arready <= 1'b1;
          end
        end
        default: r_state <= RS_IDLE;
      endcase
    end
  end

  assign w_resp = (r_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;

  assign ace.ace_arready = r_arready;
  assign ace.ace_rvalid  = r_rvalid;
  assign ace.ace_rid     = r_id;
  assign ace.ace_rdata   = (r_rvalid && !r_err) ? w_q : '0;
  assign ace.ace_rresp   = {2'b00, w_resp};
  assign ace.ace_rlast   = r_rvalid && (r_beat == r_len);
  assign proto_err       = r_proto_err;

endmodule
